// File: rtl/seg_hex_pkg.sv
// seg_hex_pkg: shared types and constants for the multi-digit hex driver.
//   seg_t      : one 7-segment pattern, order {g,f,e,d,c,b,a}, active-low
//   SEG_BLANK  : all segments off
//   SEG_ZERO   : the "0" glyph
//   SEG_TABLE  : 16-entry hex glyph table indexed by nibble value
//   state_t    : conversion FSM states {IDLE, CONV}
package seg_hex_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;
    localparam seg_t SEG_ZERO  = 7'b1000000;

    localparam seg_t SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: combinational nibble -> 7-segment glyph lookup.
//   digit : 4-bit hex value
//   blank : 1 forces all segments off
//   seg   : active-low pattern {g,f,e,d,c,b,a}
module seg_hex_decode
    import seg_hex_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output seg_t       seg
);

    // Glyph lookup with blank override.
    always_comb begin
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            seg = SEG_TABLE[digit];
        end
    end

endmodule

// File: rtl/seg_hex_multi.sv
// seg_hex_multi: multi-digit hex driver for a 7-segment bank.
// A word accepted on load_valid && load_ready is decoded one digit per
// cycle, MSB first, through one shared decoder into a shadow register,
// then committed in a single cycle so the display changes atomically.
//   clk, rst_n      : clock, asynchronous active-low reset
//   load_valid/ready: load handshake (ready only while idle)
//   load_value      : digit i = bits [4i+3:4i], digit 0 rightmost
//   blank_lz        : blank leading zeros (captured at accept)
//   blink_mask      : per-digit blink enable (captured at accept)
//   hex_seg         : digit i = bits [7i+6:7i], active-low, registered
// Optional feature macro: SEG_HEX_BLINK_EN builds the blink counter,
// blink phase and mask register; without it blink_mask is ignored.
module seg_hex_multi
    import seg_hex_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [7*NUM_DIGITS-1:0] hex_seg
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [7*NUM_DIGITS-1:0] SEG_ALL_ZERO = {NUM_DIGITS{SEG_ZERO}};

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    seen_nz_q, seen_nz_d;
    logic [4*NUM_DIGITS-1:0] value_q, value_d;
    logic                    blank_lz_q, blank_lz_d;
    logic [7*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [7*NUM_DIGITS-1:0] committed_q, committed_d;
    logic [7*NUM_DIGITS-1:0] hex_seg_q, hex_seg_d;

    logic [3:0] cur_digit_s;
    logic       dec_blank_s;
    seg_t       dec_seg_s;

    assign load_ready = (state_q == IDLE);
    assign hex_seg    = hex_seg_q;

    // Select the digit under conversion; blank it only while still in the
    // leading-zero run, and never for digit 0 so a zero value shows "0".
    always_comb begin
        cur_digit_s = value_q[4*int'(idx_q) +: 4];
        dec_blank_s = blank_lz_q && !seen_nz_q && (cur_digit_s == 4'h0)
                      && (idx_q != {IDX_W{1'b0}});
    end

    seg_hex_decode u_decode (
        .digit (cur_digit_s),
        .blank (dec_blank_s),
        .seg   (dec_seg_s)
    );

    // Conversion FSM: capture on accept, then one digit per cycle down to 0.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        seen_nz_d   = seen_nz_q;
        value_d     = value_q;
        blank_lz_d  = blank_lz_q;
        shadow_d    = shadow_q;
        committed_d = committed_q;
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    value_d    = load_value;
                    blank_lz_d = blank_lz;
                    idx_d      = IDX_LAST;
                    seen_nz_d  = 1'b0;
                    state_d    = CONV;
                end else begin
                    state_d    = IDLE;
                end
            end
            CONV: begin
                shadow_d[7*int'(idx_q) +: 7] = dec_seg_s;
                seen_nz_d = seen_nz_q | (cur_digit_s != 4'h0);
                if (idx_q == {IDX_W{1'b0}}) begin
                    // shadow_d already holds digit 0, so commit it directly.
                    committed_d = shadow_d;
                    state_d     = IDLE;
                end else begin
                    idx_d   = idx_q - IDX_W'(1);
                    state_d = CONV;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef SEG_HEX_BLINK_EN
    localparam int CNT_W = $clog2(BLINK_DIV);

    logic [CNT_W-1:0]      blink_cnt_q, blink_cnt_d;
    logic                  blink_phase_q, blink_phase_d;
    logic [NUM_DIGITS-1:0] mask_q, mask_d;

    // Free-running blink divider; phase flips on every wrap.
    always_comb begin
        if (blink_cnt_q == CNT_W'(BLINK_DIV - 1)) begin
            blink_cnt_d   = {CNT_W{1'b0}};
            blink_phase_d = ~blink_phase_q;
        end else begin
            blink_cnt_d   = blink_cnt_q + CNT_W'(1);
            blink_phase_d = blink_phase_q;
        end
    end

    // Blink mask is captured with the value at accept.
    always_comb begin
        if ((state_q == IDLE) && load_valid) begin
            mask_d = blink_mask;
        end else begin
            mask_d = mask_q;
        end
    end

    // Output pattern: committed glyphs, masked digits dark in the off phase.
    always_comb begin
        hex_seg_d = committed_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (blink_phase_q && mask_q[i]) begin
                hex_seg_d[7*i +: 7] = SEG_BLANK;
            end else begin
                hex_seg_d[7*i +: 7] = committed_q[7*i +: 7];
            end
        end
    end

    // Blink state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q   <= {CNT_W{1'b0}};
            blink_phase_q <= 1'b0;
            mask_q        <= {NUM_DIGITS{1'b0}};
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            mask_q        <= mask_d;
        end
    end
`else
    logic unused_mask_s;
    assign unused_mask_s = ^blink_mask;

    // Output pattern follows the committed glyphs directly.
    always_comb begin
        hex_seg_d = committed_q;
    end
`endif

    // Main state and data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= {IDX_W{1'b0}};
            seen_nz_q   <= 1'b0;
            value_q     <= {(4*NUM_DIGITS){1'b0}};
            blank_lz_q  <= 1'b0;
            shadow_q    <= SEG_ALL_ZERO;
            committed_q <= SEG_ALL_ZERO;
            hex_seg_q   <= SEG_ALL_ZERO;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            seen_nz_q   <= seen_nz_d;
            value_q     <= value_d;
            blank_lz_q  <= blank_lz_d;
            shadow_q    <= shadow_d;
            committed_q <= committed_d;
            hex_seg_q   <= hex_seg_d;
        end
    end

endmodule

// File: tb/tb_seg_hex_multi.sv
// tb_seg_hex_multi: directed + randomized bench for seg_hex_multi with a
// behavioural display model (glyph table + leading-zero rule).
module tb_seg_hex_multi;

    localparam int N  = 6;
    localparam int BD = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           load_valid = 1'b0;
    logic           load_ready;
    logic [4*N-1:0] load_value = '0;
    logic           blank_lz = 1'b0;
    logic [N-1:0]   blink_mask = '0;
    logic [7*N-1:0] hex_seg;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [6:0] glyph [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    seg_hex_multi #(.NUM_DIGITS(N), .BLINK_DIV(BD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_value (load_value),
        .blank_lz   (blank_lz),
        .blink_mask (blink_mask),
        .hex_seg    (hex_seg)
    );

    always #5 clk = ~clk;

    // Edges seen since reset release; the blink phase is a function of this.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Expected display for a value: hex glyphs, leading zeros dark if asked.
    function automatic logic [7*N-1:0] model(input logic [4*N-1:0] v, input logic blz);
        logic [7*N-1:0] r;
        bit seen;
        int d;
        r = '0;
        seen = 0;
        for (int i = N - 1; i >= 0; i--) begin
            d = (v >> (4 * i)) & 15;
            if (blz && !seen && d == 0 && i != 0) r[7*i +: 7] = 7'b1111111;
            else                                  r[7*i +: 7] = glyph[d];
            if (d != 0) seen = 1;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a load at a negedge, then count busy cycles; returns one
    // negedge after ready rises, i.e. once the new value must be visible.
    task automatic do_load(input logic [4*N-1:0] v, input logic blz,
                           input logic [N-1:0] m, output int lows);
        @(negedge clk);
        load_valid = 1'b1;
        load_value = v;
        blank_lz   = blz;
        blink_mask = m;
        @(negedge clk);
        load_valid = 1'b0;
        lows = 0;
        while (load_ready !== 1'b1 && lows < 30) begin
            lows++;
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    initial begin
        int lows;
        logic [4*N-1:0] v;
        logic blz;
        logic [7*N-1:0] exp;

        // Reset state.
        #7;
        check("reset_hex", hex_seg, {N{7'b1000000}});
        check("reset_ready", load_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Leading-zero blanking example.
        do_load(24'h00A3F0, 1'b1, '0, lows);
        check("lz_busy_cycles", lows, N);
        check("lz_hex", hex_seg, {7'b1111111, 7'b1111111, 7'b0001000,
                                  7'b0110000, 7'b0001110, 7'b1000000});

        // Zero value with and without blanking.
        do_load('0, 1'b1, '0, lows);
        check("zero_blz_hex", hex_seg, {{(N-1){7'b1111111}}, 7'b1000000});
        do_load('0, 1'b0, '0, lows);
        check("zero_noblz_hex", hex_seg, {N{7'b1000000}});

        // Randomized loads against the model.
        for (int k = 0; k < 10; k++) begin
            v = 24'($urandom);
            if (k % 3 == 0) v = v >> (4 * $urandom_range(0, N - 1));
            blz = 1'($urandom);
            do_load(v, blz, '0, lows);
            check("rand_busy_cycles", lows, N);
            check("rand_hex", hex_seg, model(v, blz));
        end

        // Busy load: second value waits for ready and is not lost.
        @(negedge clk);
        load_valid = 1'b1;
        load_value = 24'h123456;
        blank_lz   = 1'b0;
        blink_mask = '0;
        @(negedge clk);
        load_value = 24'hFFFFFF;
        lows = 0;
        while (load_ready !== 1'b1 && lows < 30) begin
            lows++;
            @(negedge clk);
        end
        check("busy_cycles", lows, N);
        @(negedge clk);
        check("busy_first_hex", hex_seg, model(24'h123456, 1'b0));
        check("busy_second_accepted", load_ready, 1'b0);
        load_valid = 1'b0;
        lows = 0;
        while (load_ready !== 1'b1 && lows < 30) begin
            lows++;
            @(negedge clk);
        end
        @(negedge clk);
        check("busy_second_hex", hex_seg, model(24'hFFFFFF, 1'b0));

        // Blink on digit 0.
        do_load(24'h000007, 1'b0, 6'b000001, lows);
        for (int k = 0; k < 12; k++) begin
            exp = model(24'h000007, 1'b0);
`ifdef SEG_HEX_BLINK_EN
            if (((cyc - 1) / BD) % 2 == 1) exp[6:0] = 7'b1111111;
`endif
            check("blink_hex", hex_seg, exp);
            @(negedge clk);
        end

        // Reset mid-conversion, then a fresh load with nominal latency.
        @(negedge clk);
        load_valid = 1'b1;
        load_value = 24'h9ABCDE;
        blank_lz   = 1'b0;
        blink_mask = '0;
        @(posedge clk);
        #1 load_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midconv_reset_hex", hex_seg, {N{7'b1000000}});
        check("midconv_reset_ready", load_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        v = 24'($urandom);
        do_load(v, 1'b1, '0, lows);
        check("post_reset_busy_cycles", lows, N);
        check("post_reset_hex", hex_seg, model(v, 1'b1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg_hex_multi.md
# seg_hex_multi

Parametrised multi-digit hex driver for the board's 7-segment bank. A packed binary word is accepted through a valid/ready handshake. The word is decoded one digit per cycle (MSB first) through a single shared decoder. The complete display updates atomically. Optional features are leading-zero blanking and per-digit blinking. The block sits between any value-producing logic (counters, debug registers) and the HEX pins.

## Interface
- `NUM_DIGITS`, 6: number of digits; legal range 1..8.
- `BLINK_DIV`, 25_000_000: blink half-period in clk cycles; must be ≥ 2.
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: reset is asynchronous and active-low.
- `load_valid` in 1: request to display `load_value`.
- `load_ready` out 1: block can accept a load this cycle.
- `load_value` in 4*NUM_DIGITS: digit i = bits [4i+3:4i]; digit 0 is rightmost.
- `blank_lz` in 1: blank leading zeros; sampled at accept.
- `blink_mask` in NUM_DIGITS: bit i set means digit i blinks; sampled at accept.
- `hex_seg` out 7*NUM_DIGITS: digit i = bits [7i+6:7i], order {g,f,e,d,c,b,a}, active-low (0 = lit).

## Operation
- **Accept rule:** a load is accepted when `load_valid && load_ready` is true at a rising edge. At that edge, `load_value`, `blank_lz` and `blink_mask` are captured.
- **Loads while busy:** when `load_ready` = 0, `load_valid` is ignored. Nothing is queued and nothing is lost from the current conversion.
- **FSM states:**
  - IDLE (`load_ready` = 1): on accept → CONV, with idx = NUM_DIGITS-1 and seen_nz = 0.
  - CONV (`load_ready` = 0): each cycle decodes digit idx into the shadow register, then decrements idx. When idx = 0 is decoded, shadow (including digit 0) is copied into the committed register → IDLE.
- **Leading-zero blanking:** while `blank_lz` = 1 and seen_nz = 0, a zero digit decodes to blank (7'b1111111). The first nonzero digit sets seen_nz. Digit 0 is never blanked, so value 0 shows "0".
- **Decode map (active-low):**
  - 0 → 1000000, 1 → 1111001, 2 → 0100100, 3 → 0110000
  - 4 → 0011001, 5 → 0010010, 6 → 0000010, 7 → 1111000
  - 8 → 0000000, 9 → 0011000, A → 0001000, b → 0000011
  - C → 1000110, d → 0100001, E → 0000110, F → 0001110
- **Output register:** `hex_seg` is registered every cycle from the committed value. Digit i is forced to blank when blink_phase = 1 and the captured mask bit i = 1.
- **Blink counter:** free-running, counts 0..BLINK_DIV-1 and wraps to 0. blink_phase toggles on each wrap. Counter and phase are independent of loads.
- **Reset values:**
  - `hex_seg` = 7'b1000000 per digit (all digits show "0").
  - `load_ready` = 1; FSM = IDLE.
  - Shadow, committed and mask registers cleared (committed = "0" patterns).
  - Blink counter = 0; blink_phase = 0 (visible).
- **Reset mid-CONV:** the conversion is abandoned. Reset values apply immediately, and the next load is accepted normally after deassertion.

## Timing
- **Latency:** accept at edge E0. Digits decode on E1..EN, and commit occurs at EN. `hex_seg` shows the new value after edge EN+1.
- **`load_ready`:** low from after E0 through EN; high after EN. Maximum throughput is one load per NUM_DIGITS+1 cycles.
- **Blink:** phase flips exactly every BLINK_DIV cycles. The effect appears on `hex_seg` one cycle after the flip.
- **NUM_DIGITS = 1:** CONV lasts one cycle; blanking never applies.

## Configuration
- `SEG_HEX_BLINK_EN` defined: blink counter, phase and mask register are present, behaving as described above.
- Not defined: no counter or mask logic is built. `blink_mask` is ignored, and `hex_seg` equals the committed value one cycle later. All other behaviour is unchanged.

## Structure
- Package `seg_hex_pkg`:
  - `seg_t` (7-bit) typedef.
  - `SEG_BLANK` and `SEG_ZERO` constants.
  - 16-entry decode table.
  - FSM state enum {IDLE, CONV}.
- Sub-module `seg_hex_decode`: combinational 4-bit → `seg_t` lookup plus a blank input. Exactly one instance is shared across all digits.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-simulation → all `hex_seg` digits read 1000000 and `load_ready` = 1 immediately.
- **Lz-blank load:** N=6, load 24'h00A3F0 with `blank_lz` = 1 → after E7, digits 5..0 read 1111111, 1111111, 0001000, 0110000, 0001110, 1000000, and `load_ready` is low for exactly 6 cycles.
- **Zero value:** load 0 with `blank_lz` = 1 → digits 5..1 blank and digit 0 = 1000000. With `blank_lz` = 0 → all digits read 1000000.
- **Busy load:** hold `load_valid` with 24'h123456, then drive 24'hFFFFFF during CONV → display shows 123456. The second value is accepted only at the first cycle `load_ready` = 1.
- **Blink:** `SEG_HEX_BLINK_EN` defined, BLINK_DIV = 4, mask 6'b000001, value 24'h000007 → digit 0 alternates 1111000 / 1111111 every 4 cycles while other digits are unchanged. Without the macro, digit 0 stays 1111000.
- **Reset mid-CONV:** assert `rst_n` low at E3 of a conversion → display reads all "0" and the FSM is IDLE. A fresh load afterwards completes with nominal latency.
